microcode_loader: RTL and testbench
===================================

# microcode_loader

Runtime loader for the decode stage's three microcode tables (control, alufunc, regimm). It accepts a 32-bit word stream over a valid/ready handshake, parses a header, and assembles 64-bit entries from word pairs. It issues one write per entry to the decode stage's table write port. While it runs it holds the decode pipeline, so no lookup observes a half-written table.

## Interface
- Parameters: none.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  stream word valid.
- s_ready  output  1  loader accepts word this cycle.
- s_data  input  32  stream word.
- wr_en  output  1  table write strobe, one cycle per entry.
- wr_table  output  2  0=control, 1=alufunc, 2=regimm.
- wr_addr  output  6  entry index; bit 5 always 0 when wr_table=2.
- wr_data  output  64  entry value.
- decode_hold  output  1  freeze decode/fetch while high.
- done  output  1  one-cycle pulse: load finished.
- err  output  1  one-cycle pulse: load rejected/failed.

## Operation
- Beat = cycle with s_valid & s_ready.
- Header beat fields:
  - [31:30] table select.
  - [13:8] start address.
  - [5:0] count-1, giving 1..64 entries.
  - Other bits are ignored.
- Each entry is two beats: low word, then high word. wr_data = {hi, lo}.
- States:
  - IDLE: s_ready=1. A header beat with table 0-2 latches the table, address and remaining count, then moves to LO.
  - LO: s_ready=1. A beat latches the low word, then moves to HI.
  - HI: s_ready=1. A beat registers the write (wr_en, wr_table, wr_addr, wr_data = {s_data, lo}). It then increments the address and decrements the remaining count. Next state is LO if entries remain, else CHK (macro on) or FIN.
  - CHK: see Configuration.
  - FIN: s_ready=0, one cycle. The next state is IDLE, with done=1 registered for that cycle.
- Header with table=3: err pulses the next cycle. The state stays IDLE and nothing is written. The following beat is parsed as a new header.
- Address arithmetic:
  - Tables 0/1: 6-bit increment, wraps 63→0.
  - Table 2: 5-bit increment on addr[4:0], wraps 31→0. addr[5] is forced to 0, including the start address.
  - Counts above table depth wrap and overwrite; this is legal.
- decode_hold = (state != IDLE). It is high from the cycle after header acceptance through the FIN cycle.
- rst mid-load: the state returns to IDLE on that edge and all outputs reset. Entries already written stay written. No done or err pulse is produced.
- Reset values: s_ready=0 during the rst cycle, then 1. wr_en=0, wr_table=0, wr_addr=0, wr_data=0, decode_hold=0, done=0, err=0.

## Timing
- Write latency: HI beat at edge k → wr_en high in cycle k+1 (registered output). wr_en is never high two consecutive cycles.
- Last entry (macro off): final HI beat at edge k → state FIN and wr_en in cycle k+1. done=1 and decode_hold=0 in cycle k+2. s_ready returns to 1 in cycle k+2.
- s_valid low stalls any state indefinitely, with no timeout.
- Minimum load time for N entries: 1 + 2N beats + 1 FIN cycle (macro off).
- done and err are never high in the same cycle.

## Configuration
- MICROCODE_LOADER_CHECKSUM_EN defined:
  - After the last HI beat the loader enters CHK (s_ready=1). A running XOR of all data words (lo and hi) for this load is compared with the CHK beat.
  - Match → FIN, then done pulse.
  - Mismatch → FIN, then err pulse instead of done.
  - Writes are not rolled back.
- Undefined: the CHK state and XOR register are absent, and HI goes directly to FIN.

## Test plan
- Header table=0, addr=5, count-1=0; beats lo=0x00000003, hi=0x00000000 → one wr_en with wr_table=0, wr_addr=5, wr_data=0x0000000000000003. Next cycle: FIN. Following cycle: done=1, decode_hold=0.
- Table=1, addr=62, count-1=3, four entries → wr_addr sequence 62, 63, 0, 1. decode_hold stays high throughout.
- Table=2, addr=0x3F, count-1=1 → wr_addr 31 then 0; addr[5]=0 on both.
- Header table=3 → err pulse the next cycle, no wr_en, decode_hold stays 0. The next header is then accepted normally.
- rst asserted in LO after two entries were written → IDLE on the next edge. No further wr_en, no done/err, all outputs at reset values.
- With MICROCODE_LOADER_CHECKSUM_EN, one entry lo=0x12345678, hi=0x0F0F0F0F:
  - Checksum 0x1D3B5977 → done.
  - Checksum 0x00000000 → err. The wr_en for the entry was still issued.

Source files
------------

// File: rtl/microcode_loader.sv
// Runtime loader for the decode stage's microcode tables: parses a header, then writes 64-bit entries built from word pairs.
// Optional checksum stage enabled by defining MICROCODE_LOADER_CHECKSUM_EN.
module microcode_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        wr_en,
    output logic [1:0]  wr_table,
    output logic [5:0]  wr_addr,
    output logic [63:0] wr_data,
    output logic        decode_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        CHK,
        FIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        beat;
    logic [1:0]  tbl;
    logic [5:0]  addr;
    logic [5:0]  remaining;
    logic [31:0] lo_word;
    logic [5:0]  addr_inc;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
    logic [31:0] xor_acc;
    logic        chk_fail;
`endif

    assign s_ready     = !rst && (state != FIN);
    assign beat        = s_valid && s_ready;
    assign decode_hold = (state != IDLE);

    // Table 2 is only 32 deep, so its address wraps in 5 bits with bit 5 held at 0.
    assign addr_inc = (tbl == 2'd2) ? {1'b0, addr[4:0] + 5'd1} : addr + 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (beat && s_data[31:30] != 2'd3) state_next = LO;
            LO:   if (beat) state_next = HI;
            HI: begin
                if (beat) begin
                    if (remaining != 6'd0) begin
                        state_next = LO;
                    end else begin
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = FIN;
`endif
                    end
                end
            end
`ifdef MICROCODE_LOADER_CHECKSUM_EN
            CHK:  if (beat) state_next = FIN;
`endif
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_table  <= 2'd0;
            wr_addr   <= 6'd0;
            wr_data   <= 64'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            tbl       <= 2'd0;
            addr      <= 6'd0;
            remaining <= 6'd0;
            lo_word   <= 32'd0;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
            xor_acc   <= 32'd0;
            chk_fail  <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (beat) begin
                        if (s_data[31:30] == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            tbl       <= s_data[31:30];
                            addr      <= (s_data[31:30] == 2'd2) ? {1'b0, s_data[12:8]} : s_data[13:8];
                            remaining <= s_data[5:0];
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                            xor_acc   <= 32'd0;
                            chk_fail  <= 1'b0;
`endif
                        end
                    end
                end
                LO: begin
                    if (beat) begin
                        lo_word <= s_data;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                        xor_acc <= xor_acc ^ s_data;
`endif
                    end
                end
                HI: begin
                    if (beat) begin
                        wr_en     <= 1'b1;
                        wr_table  <= tbl;
                        wr_addr   <= addr;
                        wr_data   <= {s_data, lo_word};
                        addr      <= addr_inc;
                        remaining <= remaining - 6'd1;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                        xor_acc   <= xor_acc ^ s_data;
`endif
                    end
                end
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                CHK: begin
                    if (beat) chk_fail <= (s_data != xor_acc);
                end
                FIN: begin
                    done <= !chk_fail;
                    err  <= chk_fail;
                end
`else
                FIN: done <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_microcode_loader.sv
// Self-checking bench for microcode_loader: directed and randomized loads against a queue-based reference model.
// Honours MICROCODE_LOADER_CHECKSUM_EN by appending the checksum beat to each load.
module tb_microcode_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        wr_en;
    logic [1:0]  wr_table;
    logic [5:0]  wr_addr;
    logic [63:0] wr_data;
    logic        decode_hold;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [1:0]  tbl;
        logic [5:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         obs_q[$];
    logic [31:0] lo_words[64];
    logic [31:0] hi_words[64];
    int          compared = 0;
    int          mismatched = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          exp_done = 0;
    int          exp_err = 0;
    int          consec_cnt = 0;
    int          both_cnt = 0;
    logic        prev_wr_en = 1'b0;

    microcode_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wr_en(wr_en), .wr_table(wr_table), .wr_addr(wr_addr), .wr_data(wr_data),
        .decode_hold(decode_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Observe outputs mid-cycle and log every table write and status pulse.
    always @(negedge clk) begin
        if (wr_en === 1'b1) obs_q.push_back('{tbl: wr_table, addr: wr_addr, data: wr_data});
        if (wr_en === 1'b1 && prev_wr_en) consec_cnt++;
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (done === 1'b1 && err === 1'b1) both_cnt++;
        prev_wr_en <= (wr_en === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] hdr(input int t, input int a, input int c);
        logic [15:0] r1;
        logic [1:0]  r2;
        r1 = 16'($urandom);
        r2 = 2'($urandom);
        return {2'(t), r1, 6'(a), r2, 6'(c)};
    endfunction

    // Table 2 has 32 entries and ignores address bit 5; the others have 64.
    function automatic logic [5:0] expAddr(input int t, input int a, input int i);
        if (t == 2) return 6'(((a % 32) + i) % 32);
        return 6'((a + i) % 64);
    endfunction

    task automatic applyStimulus(input logic [31:0] word);
        int waited;
        waited = 0;
        if ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = word;
        #1;
        while (s_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        compared++;
        assert (s_ready === 1'b1)
        else begin
            mismatched++;
            $error("[TB] FAIL handshake_timeout: observed s_ready %0b expected 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic sendLoad(input int t, input int a, input int c, input int n_send, input bit bad);
        logic [31:0] sum;
        sum = 32'd0;
        applyStimulus(hdr(t, a, c));
        checkOutput("hold_after_hdr", decode_hold, 1);
        for (int i = 0; i < n_send; i++) begin
            applyStimulus(lo_words[i]);
            checkOutput("wr_en_after_lo", wr_en, 0);
            applyStimulus(hi_words[i]);
            checkOutput("wr_en_after_hi", wr_en, 1);
            checkOutput("hold_in_load", decode_hold, 1);
            exp_q.push_back('{tbl: 2'(t), addr: expAddr(t, a, i), data: {hi_words[i], lo_words[i]}});
            sum = sum ^ lo_words[i] ^ hi_words[i];
        end
`ifdef MICROCODE_LOADER_CHECKSUM_EN
        if (n_send == c + 1) applyStimulus(bad ? ((sum == 32'd0) ? 32'd1 : 32'd0) : sum);
`else
        if (bad) $display("[TB] note: checksum corruption requested without checksum build");
`endif
    endtask

    task automatic checkWrites();
        checkOutput("wr_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checkOutput($sformatf("wr_table[%0d]", i), 64'(obs_q[i].tbl), 64'(exp_q[i].tbl));
            checkOutput($sformatf("wr_addr[%0d]", i), 64'(obs_q[i].addr), 64'(exp_q[i].addr));
            checkOutput($sformatf("wr_data[%0d]", i), obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Called in the FIN cycle; checks the stall cycle and the following status pulse.
    task automatic finishLoad(input bit bad);
        checkOutput("fin_ready", s_ready, 0);
        checkOutput("fin_hold", decode_hold, 1);
        checkOutput("fin_done_low", done, 0);
        @(negedge clk);
        checkOutput("done_pulse", done, bad ? 0 : 1);
        checkOutput("err_pulse", err, bad ? 1 : 0);
        checkOutput("hold_released", decode_hold, 0);
        checkOutput("ready_restored", s_ready, 1);
        if (bad) exp_err++; else exp_done++;
        checkWrites();
    endtask

    initial begin
        int  t, a, c;
        bit  bad;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'd0;
        @(negedge clk);
        checkOutput("reset_ready", s_ready, 0);
        checkOutput("reset_wr_en", wr_en, 0);
        checkOutput("reset_wr_data", wr_data, 0);
        checkOutput("reset_hold", decode_hold, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", s_ready, 1);
        @(negedge clk);

        $display("[TB] single entry to table 0");
        lo_words[0] = 32'h0000_0003;
        hi_words[0] = 32'h0000_0000;
        sendLoad(0, 5, 0, 1, 1'b0);
        finishLoad(1'b0);

        $display("[TB] table 1 wrap 62..1");
        for (int i = 0; i < 4; i++) begin
            lo_words[i] = $urandom;
            hi_words[i] = $urandom;
        end
        sendLoad(1, 62, 3, 4, 1'b0);
        finishLoad(1'b0);

        $display("[TB] table 2 start 0x3F");
        for (int i = 0; i < 2; i++) begin
            lo_words[i] = $urandom;
            hi_words[i] = $urandom;
        end
        sendLoad(2, 63, 1, 2, 1'b0);
        finishLoad(1'b0);

        $display("[TB] invalid table 3 header");
        applyStimulus(hdr(3, 7, 2));
        checkOutput("bad_hdr_err", err, 1);
        checkOutput("bad_hdr_wr_en", wr_en, 0);
        checkOutput("bad_hdr_hold", decode_hold, 0);
        checkOutput("bad_hdr_done", done, 0);
        exp_err++;
        @(negedge clk);
        checkOutput("bad_hdr_err_clear", err, 0);
        lo_words[0] = $urandom;
        hi_words[0] = $urandom;
        sendLoad(0, 17, 0, 1, 1'b0);
        finishLoad(1'b0);

        $display("[TB] reset in LO after two entries");
        for (int i = 0; i < 6; i++) begin
            lo_words[i] = $urandom;
            hi_words[i] = $urandom;
        end
        sendLoad(1, 10, 5, 2, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rst_ready_low", s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_table", wr_table, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_hold", decode_hold, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        repeat (4) @(negedge clk);
        checkWrites();

`ifdef MICROCODE_LOADER_CHECKSUM_EN
        $display("[TB] checksum match and mismatch");
        lo_words[0] = 32'h1234_5678;
        hi_words[0] = 32'h0F0F_0F0F;
        sendLoad(0, 0, 0, 1, 1'b0);
        finishLoad(1'b0);
        sendLoad(0, 0, 0, 1, 1'b1);
        finishLoad(1'b1);
`endif

        $display("[TB] randomized loads");
        for (int n = 0; n < 6; n++) begin
            t = $urandom_range(0, 2);
            a = $urandom_range(0, 63);
            c = (n == 5) ? 63 : $urandom_range(0, 7);
            for (int i = 0; i <= c; i++) begin
                lo_words[i] = $urandom;
                hi_words[i] = $urandom;
            end
`ifdef MICROCODE_LOADER_CHECKSUM_EN
            bad = 1'($urandom_range(0, 1));
`else
            bad = 1'b0;
`endif
            sendLoad(t, a, c, c + 1, bad);
            finishLoad(bad);
        end

        @(negedge clk);
        checkOutput("done_total", 64'(done_cnt), 64'(exp_done));
        checkOutput("err_total", 64'(err_cnt), 64'(exp_err));
        checkOutput("wr_en_back_to_back", 64'(consec_cnt), 0);
        checkOutput("done_err_overlap", 64'(both_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
